// File: rtl/msk_and_hpc2o_pipe_if.sv
// Bus bundle for msk_and_hpc2o_pipe: enable, start flag, share inputs and masked AND output.
// Layout of every sharing vector: bit k*D+i is share i of lane k.
interface msk_and_hpc2o_pipe_if #(
  parameter int D = 2,
  parameter int W = 1
) ();
  localparam int HPC2RND = D * (D - 1) / 2;

  logic                   en;
  logic                   in_valid;
  logic [D*W-1:0]         inb;
  logic [W*HPC2RND-1:0]   rnd;
  logic [D*W-1:0]         ina;
  logic [D*W-1:0]         out;
  logic                   out_valid;

  modport master (output en, in_valid, inb, rnd, ina, input out, out_valid);
  modport slave  (input en, in_valid, inb, rnd, ina, output out, out_valid);
endinterface

// File: rtl/msk_and_hpc2o_pipe.sv
// W-lane HPC2 masked AND at D shares (cross-domain terms only); b/rnd at t, a at t+1, out at t+2 enabled cycles.
// No backpressure: en=0 freezes all state. MSKAND_DATA_RST_EN adds reset to the data registers.
module msk_and_hpc2o_pipe #(
  parameter int D = 2,
  parameter int W = 1
) (
  input  logic                clk,
  input  logic                rst,
  msk_and_hpc2o_pipe_if.slave bus
);
  localparam int HPC2RND = D * (D - 1) / 2;

`ifdef MSKAND_DATA_RST_EN
  localparam bit DATA_RST = 1'b1;
`else
  localparam bit DATA_RST = 1'b0;
`endif

  logic                       v0;
  logic                       v1;
  logic [D*W-1:0]             b_prev;
  logic [W*HPC2RND-1:0]       r_prev;
  logic [W-1:0][D-1:0][D-1:0] term;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (bus.en) begin
      v0 <= bus.in_valid;
      v1 <= v0;
    end
  end

  assign bus.out_valid = v1;

  // Copies of b and r aligned with the a sharing that arrives one enabled cycle later.
  always_ff @(posedge clk) begin
    if (DATA_RST && rst) begin
      b_prev <= '0;
      r_prev <= '0;
    end else if (bus.en) begin
      b_prev <= bus.inb;
      r_prev <= bus.rnd;
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_lane
    for (genvar i = 0; i < D; i++) begin : g_row
      for (genvar j = 0; j < D; j++) begin : g_col
        if (j != i) begin : g_pair
          // r_ij and r_ji share one bit from the triangular packing.
          localparam int LO    = (i < j) ? i : j;
          localparam int HI    = (i < j) ? j : i;
          localparam int RI    = k * HPC2RND + LO * D - LO * (LO + 1) / 2 + (HI - 1 - LO);
          localparam bit ADD_B = (((j < i) ? j : j - 1) == 0);

          logic a_i;
          logic v_q;
          logic u_q;
          logic w_q;

          assign a_i = bus.ina[k*D+i];

          always_ff @(posedge clk) begin
            if (DATA_RST && rst) begin
              v_q <= 1'b0;
              u_q <= 1'b0;
              w_q <= 1'b0;
            end else if (bus.en) begin
              v_q <= bus.inb[k*D+j] ^ bus.rnd[RI];
              u_q <= (~a_i & r_prev[RI]) ^ (ADD_B & a_i & b_prev[k*D+i]);
              w_q <= a_i & v_q;
            end
          end

          assign term[k][i][j] = u_q ^ w_q;
        end else begin : g_diag
          assign term[k][i][j] = 1'b0;
        end
      end
      assign bus.out[k*D+i] = ^term[k][i];
    end
  end
endmodule

// File: tb/tb_msk_and_hpc2o_pipe.sv
// Directed bench for msk_and_hpc2o_pipe: a d=2,W=4 and a d=3,W=8 instance on one clock/reset.
module tb_msk_and_hpc2o_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  msk_and_hpc2o_pipe_if #(.D(2), .W(4)) bus2 ();
  msk_and_hpc2o_pipe_if #(.D(3), .W(8)) bus3 ();

  msk_and_hpc2o_pipe #(.D(2), .W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  msk_and_hpc2o_pipe #(.D(3), .W(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] share(input logic [7:0] v, input int d, input int w);
    logic [23:0] s;
    logic        acc;
    logic [31:0] r;
    s = '0;
    for (int k = 0; k < w; k++) begin
      acc = 1'b0;
      for (int i = 0; i < d - 1; i++) begin
        r = $urandom;
        s[k*d+i] = r[0];
        acc ^= r[0];
      end
      s[k*d+d-1] = v[k] ^ acc;
    end
    return s;
  endfunction

  function automatic logic [7:0] recomb(input logic [23:0] s, input int d, input int w);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < w; k++)
      for (int i = 0; i < d; i++)
        v[k] = v[k] ^ s[k*d+i];
    return v;
  endfunction

  function automatic logic [3:0] rec2(input logic [7:0] o);
    logic [7:0] t;
    t = recomb({16'b0, o}, 2, 4);
    return t[3:0];
  endfunction

  task automatic put2_b(input logic [3:0] b);
    logic [23:0] s;
    logic [31:0] r;
    s = share({4'b0, b}, 2, 4);
    bus2.inb = s[7:0];
    r = $urandom;
    bus2.rnd = r[3:0];
  endtask

  task automatic put2_a(input logic [3:0] a);
    logic [23:0] s;
    s = share({4'b0, a}, 2, 4);
    bus2.ina = s[7:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus2.en = 1'b0; bus2.in_valid = 1'b0; bus2.inb = '0; bus2.rnd = '0; bus2.ina = '0;
    bus3.en = 1'b0; bus3.in_valid = 1'b0; bus3.inb = '0; bus3.rnd = '0; bus3.ina = '0;
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_en0_valid2 got %b want 0", bus2.out_valid);
    end
    checks++;
    if (bus3.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_en0_valid3 got %b want 0", bus3.out_valid);
    end
`ifdef MSKAND_DATA_RST_EN
    checks++;
    if (bus2.out !== 8'h00) begin
      errors++; $display("FAIL reset_out2 got %h want 00", bus2.out);
    end
    checks++;
    if (bus3.out !== 24'h000000) begin
      errors++; $display("FAIL reset_out3 got %h want 000000", bus3.out);
    end
`endif
    rst = 1'b0;
    bus2.en = 1'b1;
    bus3.en = 1'b1;
    step();
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid got %b want 0", bus2.out_valid);
    end
  endtask

  task automatic test_single();
    put2_b(4'hC); bus2.in_valid = 1'b1;
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_t1 got %b want 0", bus2.out_valid);
    end
    put2_a(4'hA); put2_b(4'h0); bus2.in_valid = 1'b0;
    step();
    checks++;
    if (bus2.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid_t2 got %b want 1", bus2.out_valid);
    end
    checks++;
    if (rec2(bus2.out) !== 4'h8) begin
      errors++; $display("FAIL single_data got %h want 8", rec2(bus2.out));
    end
    put2_b(4'h0);
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_valid_t3 got %b want 0", bus2.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b_arr [256];
    logic [23:0] s;
    logic [31:0] r;
    logic [7:0]  got;
    logic [7:0]  want;
    for (int c = 0; c <= 256; c++) begin
      r = $urandom;
      if (c < 256) begin
        b_arr[c] = r[7:0];
        s = share(r[7:0], 3, 8);
        bus3.inb = s;
        bus3.in_valid = 1'b1;
      end else begin
        bus3.inb = '0;
        bus3.in_valid = 1'b0;
      end
      r = $urandom;
      bus3.rnd = r[23:0];
      if (c >= 1) begin
        want = 8'(c - 1);
        s = share(want, 3, 8);
        bus3.ina = s;
      end
      step();
      if (c == 0) begin
        checks++;
        if (bus3.out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_valid_first got %b want 0", bus3.out_valid);
        end
      end else begin
        want = 8'(c - 1) & b_arr[c-1];
        got  = recomb(bus3.out, 3, 8);
        checks++;
        if (bus3.out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_valid op %0d got %b want 1", c - 1, bus3.out_valid);
        end
        checks++;
        if (got !== want) begin
          errors++; $display("FAIL b2b_data op %0d got %h want %h", c - 1, got, want);
        end
      end
    end
  endtask

  task automatic test_en_stall();
    logic [7:0]  held;
    logic [31:0] r;
    put2_b(4'h3); bus2.in_valid = 1'b1;
    step();
    put2_a(4'h9); put2_b(4'h5); bus2.in_valid = 1'b1;
    step();
    checks++;
    if (bus2.out_valid !== 1'b1 || rec2(bus2.out) !== 4'h1) begin
      errors++; $display("FAIL stall_pre got v=%b d=%h want v=1 d=1", bus2.out_valid, rec2(bus2.out));
    end
    held = bus2.out;
    bus2.en = 1'b0;
    put2_a(4'hF);
    for (int n = 0; n < 3; n++) begin
      r = $urandom;
      bus2.inb = r[7:0];
      bus2.rnd = r[11:8];
      bus2.in_valid = 1'b1;
      step();
      checks++;
      if (bus2.out_valid !== 1'b1 || bus2.out !== held) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b out=%h want v=1 out=%h", n, bus2.out_valid, bus2.out, held);
      end
    end
    bus2.en = 1'b1; bus2.in_valid = 1'b0; put2_b(4'h0);
    step();
    checks++;
    if (bus2.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_valid got %b want 1", bus2.out_valid);
    end
    checks++;
    if (rec2(bus2.out) !== 4'h5) begin
      errors++; $display("FAIL stall_data got %h want 5", rec2(bus2.out));
    end
    put2_b(4'h0);
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_after got %b want 0", bus2.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    put2_b(4'h7); bus2.in_valid = 1'b1;
    step();
    rst = 1'b1; bus2.in_valid = 1'b0; put2_a(4'hF); put2_b(4'h0);
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_t1 got %b want 0", bus2.out_valid);
    end
    rst = 1'b0; put2_b(4'h0);
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_t2 got %b want 0", bus2.out_valid);
    end
    put2_b(4'h6); bus2.in_valid = 1'b1;
    step();
    checks++;
    if (bus2.out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_t3 got %b want 0", bus2.out_valid);
    end
    put2_a(4'h3); put2_b(4'h0); bus2.in_valid = 1'b0;
    step();
    checks++;
    if (bus2.out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_new_valid got %b want 1", bus2.out_valid);
    end
    checks++;
    if (rec2(bus2.out) !== 4'h2) begin
      errors++; $display("FAIL rstmid_new_data got %h want 2", rec2(bus2.out));
    end
  endtask

  task automatic test_probe();
    localparam int N = 2000;
    int  cnt [8];
    int  bad;
    real dv;
    real chi;
    bad = 0;
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    for (int c = 0; c <= N; c++) begin
      put2_b(4'hC); bus2.in_valid = (c < N);
      if (c >= 1) put2_a(4'hA);
      step();
      if (c >= 1) begin
        if (bus2.out_valid !== 1'b1 || rec2(bus2.out) !== 4'h8) bad++;
        for (int b = 0; b < 8; b++) cnt[b] += int'(bus2.out[b]);
      end
    end
    bus2.in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL probe_data got %0d bad results want 0", bad);
    end
    for (int b = 0; b < 8; b++) begin
      dv  = 2.0 * real'(cnt[b]) - real'(N);
      chi = dv * dv / real'(N);
      checks++;
      if (chi > 15.0) begin
        errors++; $display("FAIL probe_chi2 bit %0d got ones=%0d chi2=%f want chi2<=15", b, cnt[b], chi);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_en_stall();
    test_reset_mid();
    test_probe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
